nack_retx_scheduler: RTL and testbench
======================================

NACK_RETX_SCHEDULER -- requirements
Module: nack_retx_scheduler

Interface
REQ-001 SHALL have parameter SEQ_W, default 32: sequence-number width.
REQ-002 SHALL have parameter BMP_W, default 64: loss-bitmap width (power of two, 8..256).
REQ-003 SHALL have port clk  input  1  the only clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port id_seq  input  SEQ_W  NACK base sequence number.
REQ-006 SHALL have port id_bmp  input  BMP_W  loss bitmap; bit i set = sequence id_seq+i lost.
REQ-007 SHALL have port id_vld  input  1  NACK descriptor valid.
REQ-008 SHALL have port id_rdy  output  1  descriptor accepted when id_vld&id_rdy.
REQ-009 SHALL have port od_seq  output  SEQ_W  sequence number to retransmit.
REQ-010 SHALL have port od_last  output  1  final request of the current descriptor.
REQ-011 SHALL have port od_vld  output  1  retransmit request valid.
REQ-012 SHALL have port od_rdy  input  1  downstream accepts when od_vld&od_rdy.

Function
REQ-013 SHALL implement FSM states IDLE, EMIT; id_rdy=1 only in IDLE, registered, with no combinational path from od_rdy or id_vld.
REQ-014 SHALL, in IDLE on handshake with id_bmp!=0, latch id_seq and id_bmp into working registers and enter EMIT.
REQ-015 SHALL, in IDLE on handshake with id_bmp==0, drop the descriptor, stay in IDLE, and emit nothing.
REQ-016 SHALL present od_vld=1 the cycle after acceptance (latency 1), with od_seq = base + index of the lowest set bit of the working bitmap.
REQ-017 SHALL compute od_seq modulo 2^SEQ_W (base 0xFFFFFFFE, bit 3 -> 0x00000001).
REQ-018 SHALL hold od_seq, od_last, od_vld stable while od_vld=1 and od_rdy=0.
REQ-019 SHALL, on od handshake, clear the emitted bit; next request valid the following cycle, sustaining one request per cycle with od_rdy held high.
REQ-020 SHALL drive od_last=1 exactly when the working bitmap holds a single set bit.
REQ-021 SHALL, on handshake of the od_last request, return to IDLE with od_vld=0; id_rdy rises the next cycle (one bubble between descriptors).
REQ-022 SHALL emit requests in ascending bit-index order, never duplicating or skipping a set bit.
REQ-023 SHALL ignore id_* in EMIT (no latching, no effect).

Reset
REQ-024 SHALL, on rst_n low, immediately clear FSM to IDLE, od_vld=0, od_last=0, od_seq=0, working registers=0, id_rdy=1 after deassertion.
REQ-025 SHALL, on reset mid-EMIT, discard remaining bitmap bits without emitting them.
REQ-026 SHALL deassert reset internally without glitching od_vld (od_vld 0 for at least one cycle after rst_n rises).

Configuration
REQ-027 SHALL support macro NACK_RETX_STAT_EN: when defined, add outputs stat_desc_cnt(32), stat_req_cnt(32), stat_drop_cnt(32) counting accepted nonzero descriptors, od handshakes, and zero-bitmap drops; saturating at 0xFFFFFFFF; reset to 0.
REQ-028 SHALL, without NACK_RETX_STAT_EN, omit those ports and counters entirely; function otherwise identical.

Structure
REQ-029 SHALL place the FSM state enum and the BMP_W index-width function (clog2) in shared package nack_pkg.
REQ-030 SHALL use one sub-module nack_lsb_find (combinational lowest-set-bit index plus one-hot-remaining flag, parameter BMP_W).

Verification
REQ-031 SHALL cover: base 100, bmp 0x15, od_rdy=1 -> od_seq 100,102,104 on consecutive cycles, od_last on 104, id_rdy high 1 cycle later.
REQ-032 SHALL cover: base 0xFFFFFFFE, bmp 0x0B -> od_seq 0xFFFFFFFE, 0xFFFFFFFF, 0x00000001.
REQ-033 SHALL cover: bmp 0 accepted -> no od_vld; with STAT_EN stat_drop_cnt=1, stat_desc_cnt=0.
REQ-034 SHALL cover: base 7, bmp 0x80000000_00000001, od_rdy toggling random 50% -> od_seq 7 then 70, outputs stable while stalled, id_vld during EMIT ignored.
REQ-035 SHALL cover: rst_n pulsed low after first of three requests -> od_vld 0 immediately, no further requests, id_rdy=1 after release.

Source files
------------

// File: rtl/nack_pkg.sv
// Shared definitions for the NACK retransmit scheduler: the two-state FSM
// encoding and the helper that sizes bit-index fields from the bitmap width.
package nack_pkg;

  // IDLE waits for a loss descriptor; EMIT walks its bitmap one bit per request.
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Width of an index into a bitmap of bmp_w bits. Kept at least 1 so a
  // degenerate one-bit bitmap still yields a legal vector.
  function automatic int idx_width(input int bmp_w);
    return (bmp_w <= 1) ? 1 : $clog2(bmp_w);
  endfunction

endpackage

// File: rtl/nack_lsb_find.sv
// Lowest-set-bit finder for the loss bitmap.
// idx is the position of the least-significant set bit of bmp (0 when bmp is
// zero). one_hot is high when bmp holds exactly one set bit, which the
// scheduler uses to mark the final request of a descriptor.
module nack_lsb_find
  import nack_pkg::*;
#(
  parameter int BMP_W = 64
) (
  input  logic [BMP_W-1:0]            bmp,
  output logic [idx_width(BMP_W)-1:0] idx,
  output logic                        one_hot
);

  localparam int IDX_W = idx_width(BMP_W);

  // Priority scan from the top down so the lowest set bit is written last and wins.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // assignment; a path that leaves it unassigned would infer a latch.
    idx = '0;
    for (int i = BMP_W - 1; i >= 0; i--) begin
      if (bmp[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves zero only when exactly one bit was set.
  always_comb begin
    one_hot = (bmp != '0) && ((bmp & (bmp - BMP_W'(1))) == '0);
  end

endmodule

// File: rtl/nack_retx_scheduler.sv
// NACK retransmit scheduler.
// Accepts a descriptor (base sequence number plus loss bitmap) and emits one
// retransmit request per set bit, in ascending bit order, with
// od_seq = base + bit index (wrapping modulo 2^SEQ_W). od_last marks the
// request for the final remaining bit. Descriptors with an empty bitmap are
// accepted and dropped.
//
// Optional build macro NACK_RETX_STAT_EN adds three saturating 32-bit
// counters: accepted nonzero descriptors, retransmit handshakes and
// zero-bitmap drops.
module nack_retx_scheduler
  import nack_pkg::*;
#(
  parameter int SEQ_W = 32,
  parameter int BMP_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEQ_W-1:0] id_seq,
  input  logic [BMP_W-1:0] id_bmp,
  input  logic             id_vld,
  output logic             id_rdy,
  output logic [SEQ_W-1:0] od_seq,
  output logic             od_last,
  output logic             od_vld,
`ifdef NACK_RETX_STAT_EN
  input  logic             od_rdy,
  output logic [31:0]      stat_desc_cnt,
  output logic [31:0]      stat_req_cnt,
  output logic [31:0]      stat_drop_cnt
`else
  input  logic             od_rdy
`endif
);

  localparam int IDX_W = idx_width(BMP_W);

  state_t           state;
  state_t           state_nxt;
  logic [SEQ_W-1:0] work_seq;
  logic [SEQ_W-1:0] work_seq_nxt;
  logic [BMP_W-1:0] work_bmp;
  logic [BMP_W-1:0] work_bmp_nxt;
  logic [IDX_W-1:0] low_idx;
  logic             low_one_hot;

  nack_lsb_find #(
    .BMP_W (BMP_W)
  ) u_lsb_find (
    .bmp     (work_bmp),
    .idx     (low_idx),
    .one_hot (low_one_hot)
  );

  // Outputs come straight from registered state, so id_rdy has no
  // combinational path from id_vld or od_rdy, and od_* stay frozen while
  // the downstream stalls because nothing here changes without a handshake.
  always_comb begin
    id_rdy  = (state == IDLE);
    od_vld  = (state == EMIT);
    od_last = (state == EMIT) && low_one_hot;
    od_seq  = work_seq + SEQ_W'(low_idx);
  end

  // Next-state logic: latch a nonzero descriptor in IDLE, retire one bit per
  // downstream handshake in EMIT, and fall back to IDLE after the last bit.
  always_comb begin
    state_nxt    = state;
    work_seq_nxt = work_seq;
    work_bmp_nxt = work_bmp;
    unique case (state)
      IDLE: begin
        if (id_vld) begin
          if (id_bmp != '0) begin
            work_seq_nxt = id_seq;
            work_bmp_nxt = id_bmp;
            state_nxt    = EMIT;
          end
        end
      end
      EMIT: begin
        if (od_rdy) begin
          // x & (x-1) clears exactly the lowest set bit, the one just emitted.
          work_bmp_nxt = work_bmp & (work_bmp - BMP_W'(1));
          if (low_one_hot) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and working registers. Reset empties the bitmap so any bits still
  // pending from an interrupted descriptor are discarded, never emitted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      work_seq <= '0;
      work_bmp <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state    <= state_nxt;
      work_seq <= work_seq_nxt;
      work_bmp <= work_bmp_nxt;
    end
  end

`ifdef NACK_RETX_STAT_EN
  logic desc_fire;
  logic drop_fire;
  logic req_fire;

  // Event strobes for the statistics counters, one per counted event.
  always_comb begin
    desc_fire = (state == IDLE) && id_vld && (id_bmp != '0);
    drop_fire = (state == IDLE) && id_vld && (id_bmp == '0);
    req_fire  = (state == EMIT) && od_rdy;
  end

  // Saturating event counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_desc_cnt <= '0;
      stat_req_cnt  <= '0;
      stat_drop_cnt <= '0;
    end else begin
      if (desc_fire && (stat_desc_cnt != '1)) begin
        stat_desc_cnt <= stat_desc_cnt + 32'd1;
      end
      if (req_fire && (stat_req_cnt != '1)) begin
        stat_req_cnt <= stat_req_cnt + 32'd1;
      end
      if (drop_fire && (stat_drop_cnt != '1)) begin
        stat_drop_cnt <= stat_drop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_nack_retx_scheduler.sv
// Directed self-checking bench for nack_retx_scheduler.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// updates on the rising edge. Statistics checks are compiled only when
// NACK_RETX_STAT_EN is defined.
module tb_nack_retx_scheduler;

  localparam int SEQ_W = 32;
  localparam int BMP_W = 64;

  logic             clk;
  logic             rst_n;
  logic [SEQ_W-1:0] id_seq;
  logic [BMP_W-1:0] id_bmp;
  logic             id_vld;
  logic             id_rdy;
  logic [SEQ_W-1:0] od_seq;
  logic             od_last;
  logic             od_vld;
  logic             od_rdy;
`ifdef NACK_RETX_STAT_EN
  logic [31:0]      stat_desc_cnt;
  logic [31:0]      stat_req_cnt;
  logic [31:0]      stat_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  nack_retx_scheduler #(
    .SEQ_W (SEQ_W),
    .BMP_W (BMP_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_seq        (id_seq),
    .id_bmp        (id_bmp),
    .id_vld        (id_vld),
    .id_rdy        (id_rdy),
    .od_seq        (od_seq),
    .od_last       (od_last),
    .od_vld        (od_vld),
`ifdef NACK_RETX_STAT_EN
    .od_rdy        (od_rdy),
    .stat_desc_cnt (stat_desc_cnt),
    .stat_req_cnt  (stat_req_cnt),
    .stat_drop_cnt (stat_drop_cnt)
`else
    .od_rdy        (od_rdy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one descriptor for a single cycle at the current falling edge.
  task automatic offer(input logic [SEQ_W-1:0] seq, input logic [BMP_W-1:0] bmp);
    check("offer_id_rdy", 64'(id_rdy), 64'd1);
    id_seq = seq;
    id_bmp = bmp;
    id_vld = 1'b1;
    @(negedge clk);
    id_vld = 1'b0;
  endtask

  // With od_rdy held high, expect three back-to-back requests then idle.
  task automatic expect_three(input string tag, input logic [SEQ_W-1:0] s0,
                              input logic [SEQ_W-1:0] s1, input logic [SEQ_W-1:0] s2);
    logic [SEQ_W-1:0] exp_seq [3];
    exp_seq[0] = s0;
    exp_seq[1] = s1;
    exp_seq[2] = s2;
    for (int i = 0; i < 3; i++) begin
      check({tag, "_vld"},    64'(od_vld), 64'd1);
      check({tag, "_id_rdy"}, 64'(id_rdy), 64'd0);
      check({tag, "_seq"},    64'(od_seq), 64'(exp_seq[i]));
      check({tag, "_last"},   64'(od_last), 64'(i == 2));
      @(negedge clk);
    end
    check({tag, "_end_vld"},    64'(od_vld), 64'd0);
    check({tag, "_end_id_rdy"}, 64'(id_rdy), 64'd1);
  endtask

  initial begin
    logic [SEQ_W-1:0] exp34 [2];
    logic [SEQ_W-1:0] held_seq;
    logic             held_last;
    logic             stalled;
    int               idx;
    int               cyc;

    rst_n  = 1'b0;
    id_seq = '0;
    id_bmp = '0;
    id_vld = 1'b0;
    od_rdy = 1'b0;

    // Reset state.
    @(negedge clk);
    check("rst_od_vld",  64'(od_vld),  64'd0);
    check("rst_od_last", 64'(od_last), 64'd0);
    check("rst_od_seq",  64'(od_seq),  64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_id_rdy", 64'(id_rdy), 64'd1);
    check("post_rst_od_vld", 64'(od_vld), 64'd0);

    // Zero bitmap: accepted and dropped, nothing emitted.
    od_rdy = 1'b1;
    offer(32'd55, 64'h0);
    check("drop_od_vld",  64'(od_vld), 64'd0);
    check("drop_id_rdy",  64'(id_rdy), 64'd1);
`ifdef NACK_RETX_STAT_EN
    check("drop_stat_drop", 64'(stat_drop_cnt), 64'd1);
    check("drop_stat_desc", 64'(stat_desc_cnt), 64'd0);
`endif
    @(negedge clk);
    check("drop_od_vld2", 64'(od_vld), 64'd0);

    // Base 100, bitmap 0x15 -> 100, 102, 104 back to back.
    offer(32'd100, 64'h15);
    expect_three("r31", 32'd100, 32'd102, 32'd104);

    // Wrap: base 0xFFFFFFFE, bitmap 0x0B -> FFFFFFFE, FFFFFFFF, 00000001.
    offer(32'hFFFF_FFFE, 64'h0B);
    expect_three("r32", 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001);

    // Extreme bits with a randomly stalling downstream and junk on id_*.
    od_rdy   = 1'b0;
    exp34[0] = 32'd7;
    exp34[1] = 32'd70;
    offer(32'd7, 64'h8000_0000_0000_0001);
    id_seq  = 32'd500;
    id_bmp  = '1;
    id_vld  = 1'b1;
    idx     = 0;
    cyc     = 0;
    stalled = 1'b0;
    held_seq  = '0;
    held_last = 1'b0;
    while (idx < 2 && cyc < 200) begin
      if (stalled) begin
        check("r34_hold_seq",  64'(od_seq),  64'(held_seq));
        check("r34_hold_last", 64'(od_last), 64'(held_last));
      end
      check("r34_vld",  64'(od_vld),  64'd1);
      check("r34_seq",  64'(od_seq),  64'(exp34[idx]));
      check("r34_last", 64'(od_last), 64'(idx == 1));
      od_rdy    = 1'($urandom_range(0, 1));
      stalled   = ~od_rdy;
      held_seq  = od_seq;
      held_last = od_last;
      if (od_rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    id_vld = 1'b0;
    od_rdy = 1'b1;
    check("r34_done",    64'(idx),    64'd2);
    check("r34_end_vld", 64'(od_vld), 64'd0);
    check("r34_id_rdy",  64'(id_rdy), 64'd1);
    @(negedge clk);
    check("r34_junk_ignored", 64'(od_vld), 64'd0);
`ifdef NACK_RETX_STAT_EN
    check("stat_desc", 64'(stat_desc_cnt), 64'd3);
    check("stat_req",  64'(stat_req_cnt),  64'd8);
    check("stat_drop", 64'(stat_drop_cnt), 64'd1);
`endif

    // Reset after the first of three requests discards the rest.
    offer(32'd20, 64'h7);
    check("r35_first_seq", 64'(od_seq), 64'd20);
    check("r35_first_vld", 64'(od_vld), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("r35_rst_vld", 64'(od_vld), 64'd0);
    check("r35_rst_seq", 64'(od_seq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("r35_no_req", 64'(od_vld), 64'd0);
      check("r35_id_rdy", 64'(id_rdy), 64'd1);
    end
`ifdef NACK_RETX_STAT_EN
    check("r35_stat_req", 64'(stat_req_cnt), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
